// File: rtl/uart_rx_8n1_if.sv
// Receive-side bundle between the UART RX front-end and its consumer.
// Signals: rx (serial line, idles high), received / recv_error (one-cycle strobes),
//          rx_byte (last good byte), is_receiving (frame in progress).
`timescale 1ns/1ps
interface uart_rx_8n1_if;
  logic       rx;
  logic       received;
  logic [7:0] rx_byte;
  logic       is_receiving;
  logic       recv_error;

  // master: the receiver, which samples the line and drives the results
  modport master (
    input  rx,
    output received, rx_byte, is_receiving, recv_error
  );

  // slave: the line side plus the consumer of the results
  modport slave (
    output rx,
    input  received, rx_byte, is_receiving, recv_error
  );
endinterface

// File: rtl/uart_rx_8n1.sv
// UART 8-N-1 receiver with 16x oversampling (by default) and mid-bit sampling.
// Ports: clk, reset_n (synchronous, active-low), bus (uart_rx_8n1_if.master):
//        rx in; received / recv_error strobes, rx_byte, is_receiving out.
`timescale 1ns/1ps
module uart_rx_8n1 #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_rx_8n1_if.master bus
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE) + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    sreg;
  logic [7:0]    rx_byte_q;
  logic          received_q;
  logic          recv_error_q;
  logic          active;
  logic          tick;

  // The tick generator only runs while a frame is being timed.
  assign active = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign tick   = active && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      div_cnt      <= '0;
      tcnt         <= '0;
      bcnt         <= '0;
      sreg         <= '0;
      rx_byte_q    <= '0;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
    end else begin
      rx_m         <= bus.rx;
      rx_s         <= rx_m;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;

      if (active) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            div_cnt <= '0;
            tcnt    <= '0;
            bcnt    <= '0;
          end
        end

        // Re-check the line at the middle of the start bit; a high level
        // here means the falling edge was a glitch.
        S_START: begin
          if (tick) begin
            if (tcnt == HALF_LAST) begin
              tcnt  <= '0;
              state <= rx_s ? S_IDLE : S_DATA;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end

        // From mid start bit, each full bit period lands on mid data bit.
        S_DATA: begin
          if (tick) begin
            if (tcnt == FULL_LAST) begin
              tcnt <= '0;
              sreg <= {rx_s, sreg[7:1]};
              bcnt <= bcnt + 3'd1;
              if (bcnt == 3'd7) begin
                state <= S_STOP;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end

        // Leaving at mid stop bit lets an immediately following start edge
        // be caught without an idle gap.
        S_STOP: begin
          if (tick) begin
            if (tcnt == FULL_LAST) begin
              tcnt <= '0;
              if (rx_s) begin
                rx_byte_q  <= sreg;
                received_q <= 1'b1;
                state      <= S_IDLE;
              end else begin
                recv_error_q <= 1'b1;
                state        <= S_BREAK;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end

        // A line held low after a framing error must return high before the
        // next start edge is trusted, otherwise a break decodes as 0x00s.
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.received     = received_q;
  assign bus.recv_error   = recv_error_q;
  assign bus.rx_byte      = rx_byte_q;
  assign bus.is_receiving = active;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 with a reduced clock ratio (DIV = 8) so
// full frames stay short; a negedge monitor collects strobes and bytes.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

  localparam int  OVERSAMPLE = 16;
  localparam int  BAUD       = 9600;
  localparam int  DIV        = 8;
  localparam int  CLK_HZ     = BAUD * OVERSAMPLE * DIV;   // 1_228_800
  localparam int  BIT_CLKS   = OVERSAMPLE * DIV;          // 128
  localparam int  LATENCY    = 3 + (OVERSAMPLE / 2 + 9 * OVERSAMPLE) * DIV; // 1219
  localparam int  IR_FRAME   = (OVERSAMPLE / 2 + 9 * OVERSAMPLE) * DIV;     // 1216
  localparam int  IR_GLITCH  = (OVERSAMPLE / 2) * DIV;                      // 64
  localparam real CLK_NS     = 10.0;
  localparam real BIT_NS     = BIT_CLKS * CLK_NS;         // 1280 ns

  logic clk;
  logic reset_n;

  uart_rx_8n1_if bus ();

  uart_rx_8n1 #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  int         n_recv      = 0;
  int         n_err       = 0;
  int         n_viol      = 0;
  int         ir_cycles   = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] got_q[$];
  int         recv_cyc_q[$];

  always @(negedge clk) begin
    if (bus.received) begin
      n_recv++;
      got_q.push_back(bus.rx_byte);
      recv_cyc_q.push_back(cyc);
    end
    if (bus.recv_error) n_err++;
    if (bus.received && bus.recv_error) n_viol++;
    if ((bus.received || bus.recv_error) && prev_strobe) n_viol++;
    prev_strobe = bus.received || bus.recv_error;
    if (bus.is_receiving) ir_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8-N-1 frame, LSB first, with the given bit period.
  task automatic send_byte(input logic [7:0] b, input real bit_ns);
    bus.rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      #(bit_ns);
    end
    bus.rx = 1'b1;
    #(bit_ns);
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    #(BIT_NS * n);
  endtask

  int recv_base = 0;
  int err_base  = 0;

  task automatic expect_counts(input string tag, input int exp_recv, input int exp_err);
    check({tag, "_recv_cnt"}, 32'(n_recv - recv_base), 32'(exp_recv));
    check({tag, "_err_cnt"},  32'(n_err - err_base),   32'(exp_err));
    recv_base = n_recv;
    err_base  = n_err;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [31:0] b;
    if (got_q.size() > 0) b = {24'h0, got_q.pop_front()};
    else                  b = 32'hFFFF_FFFF;
    check(tag, b, {24'h0, exp});
  endtask

  int t0;
  int ir0;
  int lat;
  int c1;
  int c2;

  initial begin
    reset_n = 1'b0;
    bus.rx  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_received",     {31'h0, bus.received},     32'h0);
    check("rst_recv_error",   {31'h0, bus.recv_error},   32'h0);
    check("rst_is_receiving", {31'h0, bus.is_receiving}, 32'h0);
    check("rst_rx_byte",      {24'h0, bus.rx_byte},      32'h0);
    reset_n = 1'b1;
    idle_bits(2);
    recv_base = n_recv;
    err_base  = n_err;

    // Single frame: latency, byte, is_receiving window
    @(negedge clk);
    t0  = cyc;
    ir0 = ir_cycles;
    send_byte(8'h0D, BIT_NS);
    expect_counts("f0d", 1, 0);
    if (recv_cyc_q.size() > 0) lat = recv_cyc_q[recv_cyc_q.size() - 1] - t0;
    else                       lat = -1;
    check("f0d_latency", (lat >= LATENCY - 2 && lat <= LATENCY + 2) ? 32'(LATENCY) : 32'(lat),
          32'(LATENCY));
    expect_byte("f0d_byte", 8'h0D);
    check("f0d_ir_cycles", 32'(ir_cycles - ir0), 32'(IR_FRAME));
    check("f0d_ir_after",  {31'h0, bus.is_receiving}, 32'h0);
    idle_bits(2);

    // Back-to-back frames with no idle between stop and start
    @(negedge clk);
    send_byte(8'h37, BIT_NS);
    send_byte(8'h33, BIT_NS);
    expect_counts("b2b", 2, 0);
    expect_byte("b2b_byte0", 8'h37);
    expect_byte("b2b_byte1", 8'h33);
    c1 = recv_cyc_q.size() >= 2 ? recv_cyc_q[recv_cyc_q.size() - 2] : 0;
    c2 = recv_cyc_q.size() >= 2 ? recv_cyc_q[recv_cyc_q.size() - 1] : 0;
    check("b2b_spacing",
          ((c2 - c1) >= 10 * BIT_CLKS - 2 && (c2 - c1) <= 10 * BIT_CLKS + 2) ? 32'(10 * BIT_CLKS)
                                                                              : 32'(c2 - c1),
          32'(10 * BIT_CLKS));
    idle_bits(2);

    // Start-bit glitch of 3*DIV clocks
    @(negedge clk);
    ir0 = ir_cycles;
    bus.rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    expect_counts("glitch", 0, 0);
    check("glitch_ir_cycles", 32'(ir_cycles - ir0), 32'(IR_GLITCH));
    check("glitch_ir_after",  {31'h0, bus.is_receiving}, 32'h0);
    send_byte(8'h35, BIT_NS);
    expect_counts("f35", 1, 0);
    expect_byte("f35_byte", 8'h35);
    idle_bits(2);

    // Good frame, then a 20-bit break
    send_byte(8'h41, BIT_NS);
    bus.rx = 1'b0;
    #(BIT_NS * 20);
    expect_counts("brk", 1, 1);
    expect_byte("brk_good_byte", 8'h41);
    check("brk_rx_byte_held", {24'h0, bus.rx_byte},      32'h41);
    check("brk_ir_low",       {31'h0, bus.is_receiving}, 32'h0);
    idle_bits(2);
    send_byte(8'h30, BIT_NS);
    expect_counts("f30", 1, 0);
    expect_byte("f30_byte", 8'h30);
    check("f30_rx_byte", {24'h0, bus.rx_byte}, 32'h30);
    idle_bits(2);

    // Reset pulse in the middle of data bit 4 (0xF0 keeps the line high afterwards)
    fork
      send_byte(8'hF0, BIT_NS);
      begin
        #(BIT_NS * 5.5);
        @(negedge clk);
        check("abort_ir_before", {31'h0, bus.is_receiving}, 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_received",     {31'h0, bus.received},     32'h0);
        check("abort_recv_error",   {31'h0, bus.recv_error},   32'h0);
        check("abort_is_receiving", {31'h0, bus.is_receiving}, 32'h0);
        check("abort_rx_byte",      {24'h0, bus.rx_byte},      32'h0);
        reset_n = 1'b1;
      end
    join
    idle_bits(2);
    expect_counts("abort", 0, 0);
    send_byte(8'h39, BIT_NS);
    expect_counts("f39", 1, 0);
    expect_byte("f39_byte", 8'h39);
    idle_bits(2);

    // Baud rate +2% and -2%
    send_byte(8'hA5, BIT_NS / 1.02);
    idle_bits(1);
    send_byte(8'hFF, BIT_NS / 1.02);
    idle_bits(1);
    send_byte(8'hA5, BIT_NS / 0.98);
    idle_bits(1);
    send_byte(8'hFF, BIT_NS / 0.98);
    idle_bits(1);
    expect_counts("baud", 4, 0);
    expect_byte("fast_a5", 8'hA5);
    expect_byte("fast_ff", 8'hFF);
    expect_byte("slow_a5", 8'hA5);
    expect_byte("slow_ff", 8'hFF);

    check("strobe_rules", 32'(n_viol), 32'h0);
    check("no_extra_bytes", 32'(got_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
